// File: rtl/datapath_pipe.sv
// Two-stage datapath: regfile read + ALU on accept, then a memory/writeback stage that holds until mem_ack.
// Results land one edge after accept; op_ready drops while stage 2 waits on memory (or on a RAW hazard unless DATAPATH_FWD_EN).
module datapath_pipe #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk_main,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [REG_AW-1:0] DR,
    input  logic [REG_AW-1:0] SA,
    input  logic [REG_AW-1:0] SB,
    input  logic [3:0]        FS,
    input  logic [WIDTH-1:0]  const_in,
    input  logic              MB,
    input  logic              MD,
    input  logic              MW,
    input  logic              RW,
    input  logic [WIDTH-1:0]  DataIn,
    input  logic              mem_ack,
    output logic [WIDTH-1:0]  BusA,
    output logic [WIDTH-1:0]  AddrOut,
    output logic [WIDTH-1:0]  DataOut,
    output logic              mem_re,
    output logic              mem_we,
    output logic              Z,
    output logic              N,
    output logic              C,
    output logic              V,
    output logic              wb_valid
);

    localparam int NREG = 2**REG_AW;

    logic [WIDTH-1:0]  rf_q [NREG];
    logic              s2_valid_q;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              z_q, n_q, c_q, v_q;
    logic [REG_AW-1:0] dr_q;
    logic              rw_q, md_q, mw_q;

    logic              s2_done, wb_en, hazard, accept;
    logic [WIDTH-1:0]  wb_dat, rf_a, rf_b, a_d, regb, b_d;
    logic [WIDTH-1:0]  y, res_d;
    logic [WIDTH:0]    sum;
    logic              cin, c_d, v_d;

    always_comb begin
        s2_done = s2_valid_q && (!(md_q || mw_q) || mem_ack);
        wb_en   = s2_done && rw_q;
        // A write with MD also set still writes back the ALU result.
        wb_dat  = (md_q && !mw_q) ? DataIn : res_q;
        rf_a    = rf_q[SA];
        rf_b    = rf_q[SB];
`ifdef DATAPATH_FWD_EN
        a_d     = (wb_en && dr_q == SA) ? wb_dat : rf_a;
        regb    = (wb_en && dr_q == SB) ? wb_dat : rf_b;
        hazard  = 1'b0;
`else
        a_d     = rf_a;
        regb    = rf_b;
        hazard  = s2_valid_q && rw_q && (dr_q == SA || (!MB && dr_q == SB));
`endif
        b_d      = MB ? const_in : regb;
        op_ready = !s2_valid_q || (s2_done && !hazard);
        accept   = op_valid && op_ready;
    end

    always_comb begin
        y     = '0;
        cin   = 1'b0;
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (FS[2:0])
            3'b001:  cin = 1'b1;
            3'b010:  y = b_d;
            3'b011:  begin y = b_d;  cin = 1'b1; end
            3'b100:  y = ~b_d;
            3'b101:  begin y = ~b_d; cin = 1'b1; end
            3'b110:  y = '1;
            default: y = '0;
        endcase
        sum = {1'b0, a_d} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        if (!FS[3]) begin
            res_d = sum[WIDTH-1:0];
            c_d   = sum[WIDTH];
            v_d   = (a_d[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a_d[WIDTH-1]);
        end else begin
            case (FS[2:0])
                3'b000:  res_d = a_d & b_d;
                3'b001:  res_d = a_d | b_d;
                3'b010:  res_d = a_d ^ b_d;
                3'b011:  res_d = ~a_d;
                3'b100:  res_d = b_d;
                3'b101:  res_d = b_d >> 1;
                3'b110:  res_d = b_d << 1;
                default: res_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
            dr_q       <= '0;
            rw_q       <= 1'b0;
            md_q       <= 1'b0;
            mw_q       <= 1'b0;
        end else begin
            if (wb_en) rf_q[dr_q] <= wb_dat;
            if (accept) begin
                s2_valid_q <= 1'b1;
                a_q        <= a_d;
                b_q        <= b_d;
                res_q      <= res_d;
                z_q        <= (res_d == '0);
                n_q        <= res_d[WIDTH-1];
                c_q        <= c_d;
                v_q        <= v_d;
                dr_q       <= DR;
                rw_q       <= RW;
                md_q       <= MD;
                mw_q       <= MW;
            end else if (s2_done) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign BusA     = a_q;
    assign AddrOut  = a_q;
    assign DataOut  = b_q;
    assign mem_we   = s2_valid_q && mw_q;
    assign mem_re   = s2_valid_q && md_q && !mw_q;
    assign wb_valid = s2_done;
    assign Z        = z_q;
    assign N        = n_q;
    assign C        = c_q;
    assign V        = v_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Randomised bench for datapath_pipe against an architectural register/ALU model.
module tb_datapath_pipe;

    localparam int W  = 16;
    localparam int AW = 4;
`ifdef DATAPATH_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic          clk_main = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [AW-1:0] DR = '0, SA = '0, SB = '0;
    logic [3:0]    FS = '0;
    logic [W-1:0]  const_in = '0;
    logic          MB = 1'b0, MD = 1'b0, MW = 1'b0, RW = 1'b0;
    logic [W-1:0]  DataIn = '0;
    logic          mem_ack = 1'b0;
    logic [W-1:0]  BusA, AddrOut, DataOut;
    logic          mem_re, mem_we, Z, N, C, V, wb_valid;

    datapath_pipe #(.WIDTH(W), .REG_AW(AW)) dut (
        .clk_main(clk_main), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .DR(DR), .SA(SA), .SB(SB), .FS(FS), .const_in(const_in),
        .MB(MB), .MD(MD), .MW(MW), .RW(RW), .DataIn(DataIn), .mem_ack(mem_ack),
        .BusA(BusA), .AddrOut(AddrOut), .DataOut(DataOut),
        .mem_re(mem_re), .mem_we(mem_we), .Z(Z), .N(N), .C(C), .V(V), .wb_valid(wb_valid)
    );

    always #5 clk_main = ~clk_main;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  m_rf [16];
    int            last_stalls;
    bit            prv_open = 0;
    logic          prv_rw;
    logic [AW-1:0] prv_dr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected results from plain integer arithmetic: true unsigned and signed sums.
    function automatic void ref_alu(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic c, output logic v);
        longint full, ua, ub, sa, sb, ut, st;
        full = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - full : ua;
        sb = b[W-1] ? ub - full : ub;
        ut = 0; st = 0; c = 1'b0; v = 1'b0; r = '0;
        if (!fs[3]) begin
            case (fs[2:0])
                3'd1:    begin ut = ua + 1;               st = sa + 1;      end
                3'd2:    begin ut = ua + ub;              st = sa + sb;     end
                3'd3:    begin ut = ua + ub + 1;          st = sa + sb + 1; end
                3'd4:    begin ut = ua + (full - 1 - ub); st = sa - sb - 1; end
                3'd5:    begin ut = ua + (full - ub);     st = sa - sb;     end
                3'd6:    begin ut = ua + (full - 1);      st = sa - 1;      end
                default: begin ut = ua;                   st = sa;          end
            endcase
            r = ut[W-1:0];
            c = (ut >= full);
            v = (st > full / 2 - 1) || (st < -(full / 2));
        end else begin
            case (fs[2:0])
                3'd0:    r = a & b;
                3'd1:    r = a | b;
                3'd2:    r = a ^ b;
                3'd3:    r = ~a;
                3'd4:    r = b;
                3'd5:    r = b >> 1;
                3'd6:    r = b << 1;
                default: r = '0;
            endcase
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_main); #1; end
        prv_open = 0;
    endtask

    task automatic wait_accept(output int stalls);
        stalls = 0;
        @(negedge clk_main);
        while (!op_ready && stalls < 20) begin
            stalls++;
            @(negedge clk_main);
        end
        if (!op_ready) check("accept_timeout", {31'd0, op_ready}, 32'd1);
        @(posedge clk_main); #1;
        op_valid = 1'b0;
    endtask

    task automatic issue_op(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                            input logic [3:0] fs, input logic [W-1:0] k,
                            input logic mb, input logic md, input logic mw, input logic rw,
                            input int ack_dly, input logic [W-1:0] din);
        logic [W-1:0] ea, eb, er;
        logic         ec, ev, mem;
        int           st, exp_st;
        ea = m_rf[sa];
        eb = mb ? k : m_rf[sb];
        ref_alu(fs, ea, eb, er, ec, ev);
        mem = md || mw;
        exp_st = (FWD == 0 && prv_open && prv_rw && (prv_dr == sa || (!mb && prv_dr == sb))) ? 1 : 0;
        DR = dr; SA = sa; SB = sb; FS = fs; const_in = k;
        MB = mb; MD = md; MW = mw; RW = rw; op_valid = 1'b1;
        wait_accept(st);
        last_stalls = st;
        check("stalls", st, exp_st);
        check("busa", BusA, ea);
        check("addr", AddrOut, ea);
        check("dout", DataOut, eb);
        check("flags", {Z, N, C, V}, {er == '0, er[W-1], ec, ev});
        check("req", {mem_re, mem_we}, {md && !mw, mw});
        if (mem) begin
            for (int i = 0; i < ack_dly; i++) begin
                check("hold_ready", op_ready, 0);
                check("hold_req", {mem_re, mem_we, wb_valid}, {md && !mw, mw, 1'b0});
                check("hold_addr", AddrOut, ea);
                check("hold_dout", DataOut, eb);
                @(posedge clk_main); #1;
            end
            mem_ack = 1'b1;
            DataIn  = din;
            #1;
            check("wb_ack", wb_valid, 1);
            @(posedge clk_main); #1;
            mem_ack = 1'b0;
            DataIn  = W'($urandom);
            check("wb_pulse", {wb_valid, mem_re, mem_we}, 0);
        end else begin
            check("wb", wb_valid, 1);
        end
        if (rw) m_rf[dr] = (md && !mw) ? din : er;
        prv_open = !mem;
        prv_rw   = rw;
        prv_dr   = dr;
    endtask

    task automatic read_reg(input logic [3:0] r);
        issue_op(4'd0, r, 4'd0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    logic [3:0]   rdr, rsa, rsb, rfs;
    logic         rmb, rmd, rmw, rrw;
    int           rdly;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        repeat (2) @(posedge clk_main);
        #1 reset = 1'b0;
        check("rst_ready", op_ready, 1);
        check("rst_bus", {BusA, AddrOut, DataOut}, 0);
        check("rst_ctl", {mem_re, mem_we, wb_valid, Z, N, C, V}, 0);
        idle(2);
        check("idle_ready", op_ready, 1);
        for (int r = 0; r < 16; r++) read_reg(4'(r));

        // Dependent pair: R1 <- 0x00FF, then R2 <- R1 + R1.
        idle(1);
        issue_op(4'd1, 4'd0, 4'd0, 4'hC, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b1, 0, '0);
        issue_op(4'd2, 4'd1, 4'd1, 4'h2, '0, 1'b0, 1'b0, 1'b0, 1'b1, 0, '0);
        check("dep_stalls", last_stalls, (FWD != 0) ? 0 : 1);
        check("dep_zc", {Z, C}, 0);
        read_reg(4'd2);
        check("r2", BusA, 16'h01FE);

        // Increment overflow boundaries.
        issue_op(4'd3, 4'd0, 4'd0, 4'hC, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 0, '0);
        issue_op(4'd6, 4'd3, 4'd0, 4'h1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 0, '0);
        check("inc7fff_vnc", {V, N, C, Z}, 4'b1100);
        issue_op(4'd7, 4'd0, 4'd0, 4'hC, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 0, '0);
        issue_op(4'd9, 4'd7, 4'd0, 4'h1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 0, '0);
        check("incffff_zcv", {Z, C, V, N}, 4'b1100);
        read_reg(4'd6);
        check("r6", BusA, 16'h8000);

        // Memory read with a 3-cycle ack delay, then memory write of R5.
        issue_op(4'd4, 4'd2, 4'd0, 4'h0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 16'hBEEF);
        read_reg(4'd4);
        check("r4", BusA, 16'hBEEF);
        issue_op(4'd5, 4'd0, 4'd0, 4'hC, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 0, '0);
        issue_op(4'd5, 4'd2, 4'd5, 4'h0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 16'hAAAA);
        read_reg(4'd5);
        check("r5", BusA, 16'h1234);

        // Reset while a read is outstanding; a late ack must be ignored.
        DR = 4'd8; SA = 4'd1; SB = 4'd0; FS = 4'h0; MB = 1'b0; MD = 1'b1; MW = 1'b0; RW = 1'b1;
        op_valid = 1'b1;
        wait_accept(last_stalls);
        check("pend_re", mem_re, 1);
        idle(1);
        reset = 1'b1;
        @(posedge clk_main); #1;
        reset = 1'b0;
        check("rst_re", {mem_re, mem_we, wb_valid}, 0);
        check("rst_ready2", op_ready, 1);
        check("rst_busa", BusA, 0);
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        mem_ack = 1'b1;
        DataIn  = 16'hDEAD;
        #1;
        check("stray_ack", wb_valid, 0);
        @(posedge clk_main); #1;
        mem_ack = 1'b0;
        prv_open = 0;
        read_reg(4'd8);
        read_reg(4'd1);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 200; n++) begin
            rdr = 4'($urandom_range(0, 3));
            rsa = 4'($urandom_range(0, 3));
            rsb = 4'($urandom_range(0, 3));
            rfs = 4'($urandom);
            rmb = 1'($urandom);
            rrw = ($urandom_range(0, 3) != 0);
            rmd = 1'b0;
            rmw = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                rmd = 1'($urandom);
                rmw = rmd ? 1'($urandom) : 1'b1;
            end
            rdly = $urandom_range(0, 3);
            issue_op(rdr, rsa, rsb, rfs, W'($urandom), rmb, rmd, rmw, rrw, rdly, W'($urandom));
        end
        for (int r = 0; r < 4; r++) read_reg(4'(r));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Two-stage pipelined, parametrised successor to the single-cycle datapath. It combines a register file, B-operand mux, ALU and flag unit with a memory/writeback stage. That stage stalls on a memory acknowledge handshake and forwards writeback data to the next operation. It sits between the control unit, which issues one control word per accepted cycle, and the data memory.

## Interface
Parameters:
- WIDTH, 16, datapath/bus width in bits (≥4)
- REG_AW, 4, register address width; register file holds 2**REG_AW words

Ports:
- clk_main  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  control word present this cycle
- op_ready  out  1  datapath accepts the control word this cycle
- DR, SA, SB  in  REG_AW  destination / A source / B source register
- FS  in  4  ALU function select
- const_in  in  WIDTH  constant operand
- MB  in  1  B-operand select: 0 register SB, 1 const_in
- MD  in  1  writeback select: 0 ALU result, 1 DataIn (memory read)
- MW  in  1  memory write
- RW  in  1  register write enable
- DataIn  in  WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes the current request
- BusA, AddrOut, DataOut  out  WIDTH  stage-2 A operand (BusA = AddrOut), stage-2 B operand after MB mux
- mem_re, mem_we  out  1  memory read / write request
- Z, N, C, V  out  1  flags of the last ALU result
- wb_valid  out  1  stage 2 completes this cycle

## Operation
- Accept: an op is taken when op_valid && op_ready.
- Stage 1 (combinational on the accept cycle):
  - Read SA/SB, with a forward: if stage 2 writes register R this cycle, reads of R return the writeback value.
  - MB mux, then ALU.
- Stage 2 registers (on accept): A, B, result, flags, DR, RW, MD, MW; s2_valid set. If no new op is accepted, s2_valid clears on completion.
- FS (arithmetic in WIDTH bits, carry-out to C):
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A−B; 0110 A−1; 0111 A.
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 B>>1 (logical); 1110 B<<1; 1111 zero.
- Flags:
  - Z = (result==0); N = result MSB.
  - C, V (signed overflow) valid for FS 0xxx; forced 0 for FS 1xxx.
- Memory:
  - mem_we = s2_valid && MW.
  - mem_re = s2_valid && MD && !MW. With MW and MD both set, the op is a write and writeback uses the ALU result.
  - Requests hold steady until mem_ack.
- Completion: s2_done = s2_valid && (!(MD||MW) || mem_ack). On s2_done:
  - wb_valid=1.
  - If RW, register DR ← (MD && !MW) ? DataIn : result.
- op_ready = !s2_valid || s2_done (plus hazard term, see Configuration).
- mem_ack while no request is pending is ignored.

## Timing
- Reset values: BusA, AddrOut and DataOut 0; mem_re, mem_we, wb_valid 0; Z, N, C, V 0; op_ready 1; all registers 0; s2_valid 0.
- Reset mid-request drops the request; nothing is written back. Outputs take reset values the cycle after reset is sampled.
- An op accepted at edge t shows BusA, flags and requests from t+1.
- Without memory access: register write at edge t+1, wb_valid high in cycle t+1. Throughput is 1 op/cycle.
- With memory access: stage 2 holds until mem_ack; completion is in the mem_ack cycle; op_ready is low in earlier cycles.
- Back-to-back dependent ops (DR of op k = SA/SB of op k+1) see the new value with no bubble when forwarding is enabled.

## Configuration
- DATAPATH_FWD_EN defined: the forwarding path is active as above.
- DATAPATH_FWD_EN undefined: no forwarding.
  - Hazard = s2_valid && RW && (DR==SA || (!MB && DR==SB)).
  - op_ready = !s2_valid || (s2_done && !hazard).
  - The dependent op waits exactly one cycle after completion and then reads the register file.

## Test plan
- Reset then idle → all outputs 0, op_ready=1, reading R0..R15 yields 0.
- Load constant 0x00FF into R1, then R2 ← R1+R1 on the next cycle:
  - With forwarding: accepted consecutively; Z=0, C=0, R2=0x01FE.
  - Without forwarding: one bubble; same result.
- R3=0x7FFF, FS=0001 → result 0x8000, V=1, N=1, C=0. Then 0xFFFF+1 → result 0, Z=1, C=1, V=0.
- Memory read MD=1, mem_ack delayed 3 cycles, DataIn=0xBEEF:
  - op_ready low for 3 cycles, mem_re held, AddrOut stable.
  - R4=0xBEEF after ack, wb_valid one pulse.
- Memory write MW=1 with R5=0x1234 → mem_we=1, DataOut=0x1234 until ack; no register change with RW=0.
- Reset asserted during a pending read → mem_re=0 next cycle; destination register stays unchanged; a later mem_ack is ignored.
